uart_bus_responder: RTL and testbench

Memory-mapped UART responder on the CPU data bus, driven by the same rd/wr/addr/wdata signals the MEM stage issues.
- Serialises CPU-written bytes onto UART_TX through a small TX FIFO.
- Deserialises UART_RX frames into a holding register.
- Returns status/data on a combinational rdata path and raises irqout for the CPU interrupt logic.
- Sits beside data memory in the peripheral address space.

---
 rtl/uart_bus_responder_pkg.sv | 20 ++
 rtl/uart_bus_responder_tx_fifo.sv | 45 ++++
 rtl/uart_bus_responder.sv | 274 +++++++++++++++++++++++++++
 tb/tb_uart_bus_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bus_responder_pkg.sv
// Shared definitions for the memory-mapped UART responder: register offsets,
// CON bit positions and the TX/RX state encodings.
package uart_bus_responder_pkg;

  localparam logic [31:0] TxdOffset = 32'h0;
  localparam logic [31:0] RxdOffset = 32'h4;
  localparam logic [31:0] ConOffset = 32'h8;

  localparam int unsigned ConTxIntEn   = 0;
  localparam int unsigned ConRxIntEn   = 1;
  localparam int unsigned ConTxDone    = 2;
  localparam int unsigned ConRxValid   = 3;
  localparam int unsigned ConTxBusy    = 4;
  localparam int unsigned ConTxFull    = 5;
  localparam int unsigned ConRxOverrun = 6;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

endpackage

// File: rtl/uart_bus_responder_tx_fifo.sv
// Byte-wide synchronous TX FIFO; extra pointer MSB distinguishes full from empty.
module uart_tx_fifo
  import uart_bus_responder_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [Aw:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]  mem_q [Depth];
  logic        do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[Aw] != rd_ptr_q[Aw]) && (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q[Aw-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[Aw-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_bus_responder.sv
// Memory-mapped UART on the CPU data bus: TXD/RXD/CON registers, FIFO-fed
// transmitter, mid-bit sampling receiver and a registered level interrupt.
module uart_bus_responder
  import uart_bus_responder_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h40000018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irqout,
  input  logic        UART_RX,
  output logic        UART_TX
);

  localparam int unsigned   CntW    = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

  logic hit_txd, hit_rxd, hit_con, con_rd, rxd_rd;
  assign hit_txd = (addr == BASE_ADDR + TxdOffset);
  assign hit_rxd = (addr == BASE_ADDR + RxdOffset);
  assign hit_con = (addr == BASE_ADDR + ConOffset);
  assign con_rd  = rd && hit_con;
  assign rxd_rd  = rd && hit_rxd;

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  logic       tx_int_en_q, rx_int_en_q, tx_done_q, rx_valid_q, rx_overrun_q, irq_q;
  logic [7:0] last_tx_q, rx_data_q;

  // TX FIFO
  logic       fifo_push, fifo_full, fifo_empty, tx_pop;
  logic [7:0] fifo_rdata;
  assign fifo_push = wr && hit_txd;

  uart_tx_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (tx_pop),
    .wdata (wdata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Transmitter
  tx_state_e       tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_line_q, tx_line_d, tx_finish, tx_busy;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tx_pop     = 1'b0;
    tx_finish  = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        if (!fifo_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = fifo_rdata;
          tx_cnt_d   = '0;
          tx_line_d  = 1'b0;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_line_d  = tx_shift_q[0];
          tx_state_d = TxData;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxData: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_line_d  = 1'b1;
            tx_state_d = TxStop;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxStop: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = fifo_rdata;
            tx_line_d  = 1'b0;
            tx_state_d = TxStart;
          end else begin
            tx_finish  = 1'b1;
            tx_state_d = TxIdle;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  assign tx_busy = (tx_state_q != TxIdle) || !fifo_empty;
  assign UART_TX = tx_line_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // Receiver
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_meta_q, rx_sync_q, rx_last_q, rx_frame_ok;

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_frame_ok = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_last_q && !rx_sync_q) begin
          rx_cnt_d   = '0;
          rx_state_d = RxStart;
        end
      end
      RxStart: begin
        if (rx_cnt_q == CntHalf) begin
          if (rx_sync_q) begin
            rx_state_d = RxIdle;
          end else begin
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
            rx_state_d = RxData;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (rx_cnt_q == CntLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == CntLast) begin
          rx_frame_ok = rx_sync_q;
          rx_state_d  = RxIdle;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_last_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_meta_q  <= UART_RX;
      rx_sync_q  <= rx_meta_q;
      rx_last_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // Registers, status flags and interrupt; completion events win over clears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_int_en_q  <= 1'b0;
      rx_int_en_q  <= 1'b0;
      tx_done_q    <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      irq_q        <= 1'b0;
      last_tx_q    <= '0;
      rx_data_q    <= '0;
    end else begin
      if (wr && hit_con) begin
        tx_int_en_q <= wdata[ConTxIntEn];
        rx_int_en_q <= wdata[ConRxIntEn];
      end
      if (fifo_push && (!fifo_full || tx_pop)) last_tx_q <= wdata[7:0];

      if (tx_finish)   tx_done_q <= 1'b1;
      else if (con_rd) tx_done_q <= 1'b0;

      if (rx_frame_ok) rx_data_q <= rx_shift_q;

      if (rx_frame_ok) rx_valid_q <= 1'b1;
      else if (rxd_rd) rx_valid_q <= 1'b0;

      if (rx_frame_ok && rx_valid_q) rx_overrun_q <= 1'b1;
      else if (con_rd)               rx_overrun_q <= 1'b0;

      irq_q <= (tx_int_en_q && tx_done_q) || (rx_int_en_q && rx_valid_q);
    end
  end

  assign irqout = irq_q;

  always_comb begin
    rdata = '0;
    if (hit_txd) begin
      rdata[7:0] = last_tx_q;
    end else if (hit_rxd) begin
      rdata[7:0] = rx_data_q;
    end else if (hit_con) begin
      rdata[ConTxIntEn]   = tx_int_en_q;
      rdata[ConRxIntEn]   = rx_int_en_q;
      rdata[ConTxDone]    = tx_done_q;
      rdata[ConRxValid]   = rx_valid_q;
      rdata[ConTxBusy]    = tx_busy;
      rdata[ConTxFull]    = fifo_full;
      rdata[ConRxOverrun] = rx_overrun_q;
    end
  end

endmodule

// File: tb/tb_uart_bus_responder.sv
// Directed bench for uart_bus_responder at 4 clocks per bit.
module tb_uart_bus_responder;

  localparam int unsigned Cpb     = 4;
  localparam logic [31:0] Base    = 32'h40000018;
  localparam logic [31:0] AddrTxd = Base;
  localparam logic [31:0] AddrRxd = Base + 32'h4;
  localparam logic [31:0] AddrCon = Base + 32'h8;

  logic        clk = 1'b0;
  logic        reset, rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic        irqout, UART_RX, UART_TX;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_bus_responder #(
    .CLKS_PER_BIT (Cpb),
    .FIFO_DEPTH   (4),
    .BASE_ADDR    (Base)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .irqout  (irqout),
    .UART_RX (UART_RX),
    .UART_TX (UART_TX)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    rd   = 1'b0;
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a;
    rd   = 1'b1;
    #1;
    d = rdata;
    @(negedge clk);
    rd = 1'b0;
  endtask

  // Checks every cycle of a 10-bit frame; without wait_start the start bit must follow at once.
  task automatic tx_frame(input logic [7:0] b, input bit wait_start, input string tag);
    logic [9:0] bits;
    logic [3:0] s;
    int n;
    bits = {1'b1, b, 1'b0};
    if (wait_start) begin
      n = 0;
      while (UART_TX !== 1'b0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check_eq($sformatf("%s_start_seen", tag), 32'(n < 200), 32'd1);
    end
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 4; c++) begin
        s[c] = UART_TX;
        @(negedge clk);
      end
      check_eq($sformatf("%s_bit%0d", tag, i), {28'b0, s}, bits[i] ? 32'hF : 32'h0);
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      UART_RX = bits[i];
      repeat (Cpb) @(negedge clk);
    end
    UART_RX = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int highs;
    reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; UART_RX = 1'b1;
    #12;
    check_eq("rst_uart_tx", UART_TX, 1);
    check_eq("rst_irq", irqout, 0);
    peek(AddrCon, d); check_eq("rst_con", d, 0);
    peek(AddrRxd, d); check_eq("rst_rxd", d, 0);
    @(negedge clk);
    reset = 1'b1;

    // Single frame 0xA5 with TX interrupt
    bus_write(AddrCon, 32'h1);
    bus_write(AddrTxd, 32'hA5);
    peek(AddrTxd, d); check_eq("txd_readback", d, 32'hA5);
    tx_frame(8'hA5, 1'b1, "a5");
    peek(AddrCon, d); check_eq("con_tx_done", d, 32'h05);
    check_eq("irq_latency", irqout, 0);
    @(negedge clk);
    check_eq("irq_set", irqout, 1);
    repeat (5) @(negedge clk);
    check_eq("irq_hold", irqout, 1);
    bus_read(AddrCon, d); check_eq("con_rd_val", d, 32'h05);
    peek(AddrCon, d); check_eq("con_after_clear", d, 32'h01);
    @(negedge clk);
    check_eq("irq_cleared", irqout, 0);

    // Burst of five bytes, then one more into a full FIFO
    bus_write(AddrCon, 32'h0);
    fork
      begin
        @(negedge clk);
        wr   = 1'b1;
        addr = AddrTxd;
        for (int i = 1; i <= 5; i++) begin
          wdata = 32'(i);
          @(negedge clk);
        end
        wr = 1'b0;
        peek(AddrCon, d); check_eq("con_full_busy", d & 32'h30, 32'h30);
        bus_write(AddrTxd, 32'h06);
      end
      begin
        tx_frame(8'h01, 1'b1, "b1");
        tx_frame(8'h02, 1'b0, "b2");
        tx_frame(8'h03, 1'b0, "b3");
        tx_frame(8'h04, 1'b0, "b4");
        tx_frame(8'h05, 1'b0, "b5");
      end
    join
    highs = 0;
    repeat (20) begin
      @(negedge clk);
      if (UART_TX === 1'b1) highs++;
    end
    check_eq("idle_after_burst", highs, 20);
    peek(AddrCon, d); check_eq("con_burst_done", d & 32'h34, 32'h04);
    bus_read(AddrCon, d);

    // RX frame 0x3C with RX interrupt
    bus_write(AddrCon, 32'h2);
    rx_send(8'h3C, 1'b1);
    repeat (6) @(negedge clk);
    peek(AddrCon, d); check_eq("rx_valid_set", d & 32'h48, 32'h08);
    peek(AddrRxd, d); check_eq("rxd_3c", d, 32'h3C);
    check_eq("irq_rx", irqout, 1);
    bus_read(AddrRxd, d); check_eq("rxd_read_3c", d, 32'h3C);
    peek(AddrCon, d); check_eq("rx_valid_cleared", d & 32'h08, 32'h0);
    @(negedge clk);
    check_eq("irq_rx_cleared", irqout, 0);

    // Overrun: two frames without reading RXD
    rx_send(8'h11, 1'b1);
    rx_send(8'h22, 1'b1);
    repeat (6) @(negedge clk);
    peek(AddrRxd, d); check_eq("rxd_overwrite", d, 32'h22);
    peek(AddrCon, d); check_eq("con_overrun", d & 32'h48, 32'h48);
    bus_read(AddrCon, d);
    peek(AddrCon, d); check_eq("overrun_cleared", d & 32'h48, 32'h08);
    bus_read(AddrRxd, d);

    // Glitch and framing error
    @(negedge clk); UART_RX = 1'b0;
    @(negedge clk); UART_RX = 1'b1;
    repeat (20) @(negedge clk);
    peek(AddrCon, d); check_eq("glitch_no_valid", d & 32'h08, 32'h0);
    rx_send(8'h55, 1'b0);
    repeat (6) @(negedge clk);
    peek(AddrCon, d); check_eq("framing_no_valid", d & 32'h08, 32'h0);
    peek(AddrRxd, d); check_eq("framing_rxd_kept", d, 32'h22);

    // Reset in the middle of a TX frame, with an RX interrupt pending
    bus_write(AddrCon, 32'h3);
    rx_send(8'h77, 1'b1);
    repeat (6) @(negedge clk);
    check_eq("irq_before_reset", irqout, 1);
    bus_write(AddrTxd, 32'h5A);
    highs = 0;
    while (UART_TX !== 1'b0 && highs < 200) begin
      @(negedge clk);
      highs++;
    end
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_eq("midrst_uart_tx", UART_TX, 1);
    check_eq("midrst_irq", irqout, 0);
    peek(AddrCon, d); check_eq("midrst_con", d, 0);
    peek(AddrRxd, d); check_eq("midrst_rxd", d, 0);
    @(negedge clk);
    reset = 1'b1;
    highs = 0;
    repeat (60) begin
      @(negedge clk);
      if (UART_TX === 1'b1) highs++;
    end
    check_eq("post_rst_idle", highs, 60);
    peek(AddrCon, d); check_eq("post_rst_con", d, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
